// File: rtl/ps_cmpt_pkg.sv
// Shared constants for the compute-issue scheduler: unit codes, instruction
// field positions and the fixed single-cycle latency of ALU/SHF.
package ps_cmpt_pkg;

  localparam logic [1:0] UNIT_ALU = 2'b00;
  localparam logic [1:0] UNIT_MUL = 2'b01;
  localparam logic [1:0] UNIT_SHF = 2'b10;
  localparam logic [1:0] UNIT_ILL = 2'b11;

  localparam int UNIT_HI  = 20;
  localparam int UNIT_LO  = 19;
  localparam int CTL_HI   = 18;
  localparam int CTL_LO   = 12;
  localparam int DEST_HI  = 11;
  localparam int DEST_LO  = 8;
  localparam int SRC0_HI  = 7;
  localparam int SRC0_LO  = 4;
  localparam int SRC1_HI  = 3;
  localparam int SRC1_LO  = 0;

  // Control bits with scheduling meaning
  localparam int MUL_MODE_HI = 18;  // [18:17]!=0 -> MUL reads both sources
  localparam int MUL_MODE_LO = 17;
  localparam int NO_SRC1_BIT = 16;  // ALU/SHF: no src1; MUL: no RF write
  localparam int ALU_NOWB    = 14;  // ALU: no RF write

  localparam logic [3:0] LAT_ALU_SHF = 4'd1;

endpackage

// File: rtl/ps_cmpt_wb_slots.sv
// Write-back slot pipeline. Slot k holds a result due to write the RF k
// cycles from now; slot 1 is the write happening this cycle. Writers load
// the slot matching their latency after the shift.
module ps_cmpt_wb_slots
  import ps_cmpt_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_en_i,
  input  logic [3:0] ld_lat_i,
  input  logic [3:0] ld_addr_i,
  input  logic [1:0] ld_unit_i,
  input  logic [3:0] q_lat_i,
  output logic       conflict_o,
  output logic       hd_vld_o,
  output logic [3:0] hd_addr_o,
  output logic [1:0] hd_unit_o,
  output logic       any_vld_o
);

  logic [MUL_LAT:1]      vld_q,  vld_d;
  logic [MUL_LAT:1][3:0] addr_q, addr_d;
  logic [MUL_LAT:1][1:0] unit_q, unit_d;

  // Shift toward slot 1, then drop the new writer into its latency slot
  always_comb begin
    vld_d  = '0;
    addr_d = '0;
    unit_d = '0;
    for (int k = 1; k < MUL_LAT; k++) begin
      vld_d[k]  = vld_q[k+1];
      addr_d[k] = addr_q[k+1];
      unit_d[k] = unit_q[k+1];
    end
    for (int k = 1; k <= MUL_LAT; k++) begin
      if (ld_en_i && ld_lat_i == 4'(k)) begin
        vld_d[k]  = 1'b1;
        addr_d[k] = ld_addr_i;
        unit_d[k] = ld_unit_i;
      end
    end
  end

  // Slot registers; reset drops any in-flight write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      addr_q <= '0;
      unit_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      unit_q <= unit_d;
    end
  end

  // A latency-L writer collides with whatever now sits in slot L+1, since
  // that entry shifts into slot L at the same edge
  always_comb begin
    conflict_o = 1'b0;
    for (int k = 1; k < MUL_LAT; k++) begin
      if (q_lat_i == 4'(k)) conflict_o = vld_q[k+1];
    end
  end

  assign hd_vld_o  = vld_q[1];
  assign hd_addr_o = vld_q[1] ? addr_q[1] : 4'd0;
  assign hd_unit_o = vld_q[1] ? unit_q[1] : 2'd0;
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/ps_cmpt_sched.sv
// In-order issue scheduler for ALU/MUL/SHF: decodes register usage, checks
// RAW/WAW/write-port hazards against a 16-entry scoreboard and the slot
// pipeline, and issues or stalls the presented instruction.
module ps_cmpt_sched
  import ps_cmpt_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpt_en,
  input  logic [20:0]      bt_5t25,
  output logic             ps_cmpt_stall,
  output logic             ps_alu_go,
  output logic             ps_mul_go,
  output logic             ps_shf_go,
  output logic             ps_cmpt_illegal,
  output logic             ps_rf_wb_en,
  output logic [3:0]       ps_rf_wb_a,
  output logic [1:0]       ps_rf_wb_unit,
  output logic             ps_cmpt_busy,
  output logic [CNT_W-1:0] ps_stall_cnt
);

  logic [1:0]       unit;
  logic [3:0]       dest, src0, src1, lat;
  logic             is_alu, is_mul, is_shf, mul_2src;
  logic             src0_used, src1_used, writer;
  logic             raw, waw, port_cf, unit_ok, issue;
  logic [15:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hd_vld, slots_any;
  logic [3:0]       hd_addr;
  logic [1:0]       hd_unit;

  assign unit     = bt_5t25[UNIT_HI:UNIT_LO];
  assign dest     = bt_5t25[DEST_HI:DEST_LO];
  assign src0     = bt_5t25[SRC0_HI:SRC0_LO];
  assign src1     = bt_5t25[SRC1_HI:SRC1_LO];
  assign is_alu   = unit == UNIT_ALU;
  assign is_mul   = unit == UNIT_MUL;
  assign is_shf   = unit == UNIT_SHF;
  assign mul_2src = bt_5t25[MUL_MODE_HI:MUL_MODE_LO] != 2'b00;

  assign src0_used = is_alu | is_shf | (is_mul & mul_2src);
  assign src1_used = ((is_alu | is_shf) & ~bt_5t25[NO_SRC1_BIT]) | (is_mul & mul_2src);
  assign writer    = (is_alu & ~bt_5t25[ALU_NOWB]) | (is_mul & ~bt_5t25[NO_SRC1_BIT]) | is_shf;
  assign lat       = is_mul ? 4'(MUL_LAT) : LAT_ALU_SHF;

  // No bypass: a busy source holds the reader until the write-back edge
  assign raw     = (src0_used & busy_q[src0]) | (src1_used & busy_q[src1]);
  assign waw     = writer & busy_q[dest];
  assign unit_ok = rst & cpt_en & (unit != UNIT_ILL);

  assign ps_cmpt_stall   = unit_ok & (raw | waw | (writer & port_cf));
  assign issue           = unit_ok & ~ps_cmpt_stall;
  assign ps_alu_go       = issue & is_alu;
  assign ps_mul_go       = issue & is_mul;
  assign ps_shf_go       = issue & is_shf;
  assign ps_cmpt_illegal = rst & cpt_en & (unit == UNIT_ILL);

  ps_cmpt_wb_slots #(.MUL_LAT(MUL_LAT)) u_slots (
    .clk       (clk),
    .rst       (rst),
    .ld_en_i   (issue & writer),
    .ld_lat_i  (lat),
    .ld_addr_i (dest),
    .ld_unit_i (unit),
    .q_lat_i   (lat),
    .conflict_o(port_cf),
    .hd_vld_o  (hd_vld),
    .hd_addr_o (hd_addr),
    .hd_unit_o (hd_unit),
    .any_vld_o (slots_any)
  );

  // Clear the register finishing write-back, then set the new dest (set wins)
  always_comb begin
    busy_d = busy_q;
    if (hd_vld) busy_d[hd_addr] = 1'b0;
    if (issue && writer) busy_d[dest] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                cnt_q <= '0;
    else if (ps_cmpt_stall && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign ps_rf_wb_en   = hd_vld;
  assign ps_rf_wb_a    = hd_addr;
  assign ps_rf_wb_unit = hd_unit;
  assign ps_cmpt_busy  = slots_any | (|busy_q);
  assign ps_stall_cnt  = cnt_q;

  // Control bits that only the execution units interpret
  logic unused_ctl;
  assign unused_ctl = &{1'b0, bt_5t25[15], bt_5t25[13:12]};

endmodule

// File: tb/tb_ps_cmpt_sched.sv
// Directed bench for ps_cmpt_sched with MUL_LAT=3: issue, RAW stall,
// write-port conflict, illegal unit, non-writing MUL and mid-flight reset.
module tb_ps_cmpt_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpt_en;
  logic [20:0] bt_5t25;
  logic        ps_cmpt_stall, ps_alu_go, ps_mul_go, ps_shf_go, ps_cmpt_illegal;
  logic        ps_rf_wb_en, ps_cmpt_busy;
  logic [3:0]  ps_rf_wb_a;
  logic [1:0]  ps_rf_wb_unit;
  logic [15:0] ps_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ps_cmpt_sched #(.MUL_LAT(3), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpt_en         (cpt_en),
    .bt_5t25        (bt_5t25),
    .ps_cmpt_stall  (ps_cmpt_stall),
    .ps_alu_go      (ps_alu_go),
    .ps_mul_go      (ps_mul_go),
    .ps_shf_go      (ps_shf_go),
    .ps_cmpt_illegal(ps_cmpt_illegal),
    .ps_rf_wb_en    (ps_rf_wb_en),
    .ps_rf_wb_a     (ps_rf_wb_a),
    .ps_rf_wb_unit  (ps_rf_wb_unit),
    .ps_cmpt_busy   (ps_cmpt_busy),
    .ps_stall_cnt   (ps_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] ins(input logic [1:0] u, input logic [6:0] ctl,
                                      input logic [3:0] d, input logic [3:0] s0,
                                      input logic [3:0] s1);
    return {u, ctl, d, s0, s1};
  endfunction

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs at cycle start, let combinational outputs settle
  task automatic drv(input logic en, input logic [20:0] b);
    cpt_en  = en;
    bt_5t25 = b;
    #1;
  endtask

  task automatic chk_go(input string tag, input logic a, input logic m, input logic s,
                        input logic st);
    chk({tag, ".alu_go"}, 32'(ps_alu_go), 32'(a));
    chk({tag, ".mul_go"}, 32'(ps_mul_go), 32'(m));
    chk({tag, ".shf_go"}, 32'(ps_shf_go), 32'(s));
    chk({tag, ".stall"},  32'(ps_cmpt_stall), 32'(st));
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [3:0] a,
                        input logic [1:0] u);
    chk({tag, ".wb_en"},   32'(ps_rf_wb_en), 32'(en));
    chk({tag, ".wb_a"},    32'(ps_rf_wb_a), 32'(a));
    chk({tag, ".wb_unit"}, 32'(ps_rf_wb_unit), 32'(u));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_go(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_wb(tag, 1'b0, 4'd0, 2'd0);
    chk({tag, ".illegal"}, 32'(ps_cmpt_illegal), 32'd0);
    chk({tag, ".busy"},    32'(ps_cmpt_busy), 32'd0);
    chk({tag, ".cnt"},     32'(ps_stall_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drv(1'b0, '0);
    cyc(); cyc();
    chk_all_zero("reset");
    #3 rst = 1'b1;
    cyc();

    // 1: single ALU R3 <= R1 op R2
    drv(1'b1, ins(2'b00, 7'd0, 4'd3, 4'd1, 4'd2));
    chk_go("t1.c0", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); drv(1'b0, '0);
    chk_wb("t1.c1", 1'b1, 4'd3, 2'b00);
    chk("t1.c1.busy", 32'(ps_cmpt_busy), 32'd1);
    cyc();
    chk("t1.c2.busy", 32'(ps_cmpt_busy), 32'd0);
    chk_wb("t1.c2", 1'b0, 4'd0, 2'b00);

    // 2: RAW on R3, reader issues after producer's write-back cycle
    cyc(); drv(1'b1, ins(2'b00, 7'd0, 4'd3, 4'd1, 4'd2));
    chk_go("t2.c0", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); drv(1'b1, ins(2'b00, 7'd0, 4'd4, 4'd3, 4'd0));
    chk_go("t2.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_wb("t2.c1", 1'b1, 4'd3, 2'b00);
    cyc();
    chk_go("t2.c2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2.c2.cnt", 32'(ps_stall_cnt), 32'd1);
    cyc(); drv(1'b0, '0);
    chk_wb("t2.c3", 1'b1, 4'd4, 2'b00);
    cyc();

    // 3: MUL R5 then ALU R6 two cycles later collides on the write port
    drv(1'b1, ins(2'b01, 7'd0, 4'd5, 4'd1, 4'd2));
    chk_go("t3.c0", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); drv(1'b0, '0);
    chk_wb("t3.c1", 1'b0, 4'd0, 2'b00);
    cyc(); drv(1'b1, ins(2'b00, 7'd0, 4'd6, 4'd8, 4'd9));
    chk_go("t3.c2", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_go("t3.c3", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_wb("t3.c3", 1'b1, 4'd5, 2'b01);
    cyc(); drv(1'b0, '0);
    chk_wb("t3.c4", 1'b1, 4'd6, 2'b00);
    chk("t3.c4.cnt", 32'(ps_stall_cnt), 32'd2);
    cyc();
    chk("t3.c5.busy", 32'(ps_cmpt_busy), 32'd0);

    // 4: illegal unit
    drv(1'b1, ins(2'b11, 7'd0, 4'd2, 4'd1, 4'd1));
    chk("t4.illegal", 32'(ps_cmpt_illegal), 32'd1);
    chk_go("t4.c0", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); drv(1'b0, '0);
    chk("t4.c1.illegal", 32'(ps_cmpt_illegal), 32'd0);
    chk("t4.c1.busy", 32'(ps_cmpt_busy), 32'd0);
    chk_wb("t4.c1", 1'b0, 4'd0, 2'b00);

    // 5: non-writing MUL ([16]=1), then a reader of its dest issues at once
    cyc(); drv(1'b1, ins(2'b01, 7'b0010000, 4'd7, 4'd1, 4'd2));
    chk_go("t5.c0", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); drv(1'b1, ins(2'b00, 7'd0, 4'd8, 4'd7, 4'd7));
    chk_go("t5.c1", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_wb("t5.c1", 1'b0, 4'd0, 2'b00);
    cyc(); drv(1'b1, ins(2'b10, 7'd0, 4'd9, 4'd1, 4'd2));
    chk_wb("t5.c2", 1'b1, 4'd8, 2'b00);
    chk_go("t5.c2.shf", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(); drv(1'b0, '0);
    chk_wb("t5.c3", 1'b1, 4'd9, 2'b10);
    cyc();
    chk("t5.c4.busy", 32'(ps_cmpt_busy), 32'd0);

    // 6: reset while a MUL is in flight
    drv(1'b1, ins(2'b01, 7'd0, 4'd7, 4'd1, 4'd2));
    chk_go("t6.c0", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); drv(1'b0, '0);
    rst = 1'b0;
    #1;
    chk_all_zero("t6.rst");
    cyc();
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t6.post.wb_en", 32'(ps_rf_wb_en), 32'd0);
    end
    drv(1'b1, ins(2'b00, 7'd0, 4'd10, 4'd7, 4'd7));
    chk_go("t6.reader", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); drv(1'b0, '0);
    chk_wb("t6.reader.wb", 1'b1, 4'd10, 2'b00);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
